// File: rtl/lite_board_regbank_if.sv
// Bus bundle for lite_board_regbank: Xillybus Lite access port, committed-row
// stream and info-text RAM write port.
interface lite_board_regbank_if #(
  parameter int unsigned ROWS      = 19,
  parameter int unsigned ROW_W     = 38,
  parameter int unsigned TXT_DEPTH = 512
);
  localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned TA_W  = $clog2(TXT_DEPTH);

  logic              user_wren;
  logic              user_rden;
  logic [3:0]        user_wstrb;
  logic [31:0]       user_addr;
  logic [31:0]       user_wr_data;
  logic [31:0]       user_rd_data;
  logic              row_valid;
  logic              row_ready;
  logic [IDX_W-1:0]  row_index;
  logic [ROW_W-1:0]  row_data;
  logic              txt_we;
  logic [TA_W-1:0]   txt_addr;
  logic [7:0]        txt_data;

  modport master (
    output user_wren, user_rden, user_wstrb, user_addr, user_wr_data, row_ready,
    input  user_rd_data, row_valid, row_index, row_data, txt_we, txt_addr, txt_data
  );

  modport slave (
    input  user_wren, user_rden, user_wstrb, user_addr, user_wr_data, row_ready,
    output user_rd_data, row_valid, row_index, row_data, txt_we, txt_addr, txt_data
  );
endinterface

// File: rtl/lite_board_regbank.sv
// Board row register bank behind Xillybus Lite: low-word writes commit whole rows
// into a small FIFO feeding the renderer; text writes stream into an 8-bit RAM.
module lite_board_regbank #(
  parameter int unsigned ROWS       = 19,
  parameter int unsigned ROW_W      = 38,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TXT_BASE   = 64,
  parameter int unsigned TXT_DEPTH  = 512
) (
  input logic                 user_clk,
  input logic                 arst_n,
  lite_board_regbank_if.slave bus
);
  localparam int unsigned HI_W  = ROW_W - 32;
  localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned TA_W  = $clog2(TXT_DEPTH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0]      r_low  [ROWS];
  logic [HI_W-1:0]  r_high [ROWS];
  logic [IDX_W-1:0] r_fifo_idx [FIFO_DEPTH];
  logic [ROW_W-1:0] r_fifo_dat [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [LVL_W-1:0] r_level;
  logic [15:0]      r_drop_cnt;
  logic [31:0]      r_rd_data;
  logic             r_txt_we;
  logic [TA_W-1:0]  r_txt_addr;
  logic [7:0]       r_txt_data;

  logic [31:0]      w_word, w_hoff, w_toff;
  logic [IDX_W-1:0] w_lrow, w_hrow;
  logic             w_is_low, w_is_high, w_is_stat, w_is_txt;
  logic [31:0]      w_low_new, w_high_ext, w_high_new, w_status, w_rd_mux;
  logic             w_full, w_nempty, w_pop, w_wr_low, w_push_ok, w_drop, w_txt_wr;
  logic [7:0]       w_txt_byte;
  logic             w_unused;

  assign w_word    = {22'd0, bus.user_addr[11:2]};
  assign w_hoff    = w_word - ROWS;
  assign w_toff    = w_word - TXT_BASE;
  assign w_lrow    = w_word[IDX_W-1:0];
  assign w_hrow    = w_hoff[IDX_W-1:0];
  assign w_is_low  = w_word < ROWS;
  assign w_is_high = (w_word >= ROWS) && (w_word < 2 * ROWS);
  assign w_is_stat = w_word == 2 * ROWS;
  assign w_is_txt  = (w_word >= TXT_BASE) && (w_word < TXT_BASE + TXT_DEPTH);
  assign w_unused  = ^{bus.user_addr[31:12], bus.user_addr[1:0], w_hoff, w_toff, w_high_new};

  always_comb begin
    w_high_ext = '0;
    w_high_ext[HI_W-1:0] = r_high[w_hrow];
  end

  assign w_low_new  = merge(r_low[w_lrow], bus.user_wr_data, bus.user_wstrb);
  assign w_high_new = merge(w_high_ext, bus.user_wr_data, bus.user_wstrb);

  assign w_full    = r_level == LVL_W'(FIFO_DEPTH);
  assign w_nempty  = r_level != '0;
  assign w_pop     = w_nempty & bus.row_ready;
  assign w_wr_low  = bus.user_wren & w_is_low;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = w_wr_low & (~w_full | w_pop);
  assign w_drop    = w_wr_low & w_full & ~w_pop;
  assign w_txt_wr  = bus.user_wren & w_is_txt & (|bus.user_wstrb);
  assign w_status  = {r_drop_cnt, 8'h00, 4'(r_level), 2'b00, w_full, w_nempty};

  always_comb begin
    w_txt_byte = bus.user_wr_data[7:0];
    if      (bus.user_wstrb[0]) w_txt_byte = bus.user_wr_data[7:0];
    else if (bus.user_wstrb[1]) w_txt_byte = bus.user_wr_data[15:8];
    else if (bus.user_wstrb[2]) w_txt_byte = bus.user_wr_data[23:16];
    else if (bus.user_wstrb[3]) w_txt_byte = bus.user_wr_data[31:24];
  end

  always_comb begin
    w_rd_mux = '0;
    if      (w_is_low)  w_rd_mux = r_low[w_lrow];
    else if (w_is_high) w_rd_mux = w_high_ext;
    else if (w_is_stat) w_rd_mux = w_status;
  end

  always_ff @(posedge user_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ROWS; i++) begin
        r_low[i]  <= '0;
        r_high[i] <= '0;
      end
    end else if (bus.user_wren) begin
      if (w_is_low)  r_low[w_lrow]  <= w_low_new;
      if (w_is_high) r_high[w_hrow] <= w_high_new[HI_W-1:0];
    end
  end

  always_ff @(posedge user_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_idx[i] <= '0;
        r_fifo_dat[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) begin
        // High half is the value held before this cycle.
        r_fifo_idx[r_wptr] <= w_lrow;
        r_fifo_dat[r_wptr] <= {r_high[w_lrow], w_low_new};
        r_wptr             <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push_ok && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push_ok && w_pop) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge user_clk or negedge arst_n) begin
    if (!arst_n) begin
      r_drop_cnt <= '0;
      r_rd_data  <= '0;
      r_txt_we   <= 1'b0;
      r_txt_addr <= '0;
      r_txt_data <= '0;
    end else begin
      if (bus.user_wren && w_is_stat && (|bus.user_wstrb)) r_drop_cnt <= '0;
      else if (w_drop && r_drop_cnt != 16'hFFFF)          r_drop_cnt <= r_drop_cnt + 1'b1;
      if (bus.user_rden) r_rd_data <= w_rd_mux;
      r_txt_we <= w_txt_wr;
      if (w_txt_wr) begin
        r_txt_addr <= w_toff[TA_W-1:0];
        r_txt_data <= w_txt_byte;
      end
    end
  end

  assign bus.row_valid    = w_nempty;
  assign bus.row_index    = r_fifo_idx[r_rptr];
  assign bus.row_data     = r_fifo_dat[r_rptr];
  assign bus.user_rd_data = r_rd_data;
  assign bus.txt_we       = r_txt_we;
  assign bus.txt_addr     = r_txt_addr;
  assign bus.txt_data     = r_txt_data;
endmodule

// File: tb/tb_lite_board_regbank.sv
// Directed bench for lite_board_regbank: row commit stream, FIFO overflow,
// text port, strobe merging, read-before-write and mid-run reset.
module tb_lite_board_regbank;
  localparam int unsigned ROWS      = 19;
  localparam int unsigned ROW_W     = 38;
  localparam int unsigned TXT_DEPTH = 512;
  localparam int unsigned STAT_W    = 2 * ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lite_board_regbank_if #(.ROWS(ROWS), .ROW_W(ROW_W), .TXT_DEPTH(TXT_DEPTH)) bus ();

  lite_board_regbank #(
    .ROWS(ROWS), .ROW_W(ROW_W), .FIFO_DEPTH(4), .TXT_BASE(64), .TXT_DEPTH(TXT_DEPTH)
  ) dut (
    .user_clk (clk),
    .arst_n   (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input int w, input logic [31:0] d, input logic [3:0] s);
    bus.user_addr    = 32'(w) << 2;
    bus.user_wr_data = d;
    bus.user_wstrb   = s;
    bus.user_wren    = 1'b1;
    @(posedge clk); #1;
    bus.user_wren    = 1'b0;
  endtask

  task automatic rd(input int w, output logic [31:0] d);
    bus.user_addr = 32'(w) << 2;
    bus.user_rden = 1'b1;
    @(posedge clk); #1;
    bus.user_rden = 1'b0;
    d = bus.user_rd_data;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [31:0] rv;
  int exp_idx [4] = '{1, 2, 3, 5};

  initial begin
    bus.user_wren = 1'b0; bus.user_rden = 1'b0; bus.user_wstrb = '0;
    bus.user_addr = '0; bus.user_wr_data = '0; bus.row_ready = 1'b0;
    step(); step();
    check("rst_row_valid", 64'(bus.row_valid), 64'd0);
    check("rst_txt_we",    64'(bus.txt_we), 64'd0);
    check("rst_row_index", 64'(bus.row_index), 64'd0);
    check("rst_row_data",  64'(bus.row_data), 64'd0);
    check("rst_txt_addr",  64'(bus.txt_addr), 64'd0);
    check("rst_txt_data",  64'(bus.txt_data), 64'd0);
    check("rst_rd_data",   64'(bus.user_rd_data), 64'd0);
    rst_n = 1'b1;
    step();
    rd(STAT_W, rv);
    check("rst_status", 64'(rv), 64'd0);

    // High write does not commit; low write commits with one-cycle latency.
    wr(19, 32'h0000_003F, 4'hF);
    check("high_no_commit", 64'(bus.row_valid), 64'd0);
    wr(0, 32'h1234_5678, 4'hF);
    check("commit_valid", 64'(bus.row_valid), 64'd1);
    check("commit_index", 64'(bus.row_index), 64'd0);
    check("commit_data",  64'(bus.row_data), 64'h3F_1234_5678);
    step();
    check("head_stable", 64'(bus.row_data), 64'h3F_1234_5678);
    bus.row_ready = 1'b1; step(); bus.row_ready = 1'b0;
    check("pop_empty", 64'(bus.row_valid), 64'd0);
    wr(19, 32'hFFFF_FFFF, 4'hF);
    rd(19, rv);
    check("high_truncate", 64'(rv), 64'h3F);

    // Overflow: five commits into a 4-deep FIFO with no consumer.
    for (int i = 0; i < 5; i++) wr(i, 32'h100 + 32'(i), 4'hF);
    rd(STAT_W, rv);
    check("status_full_drop", 64'(rv), 64'h0001_0043);
    rd(4, rv);
    check("dropped_row_stored", 64'(rv), 64'h104);
    wr(STAT_W, 32'h0, 4'h1);
    rd(STAT_W, rv);
    check("status_drop_clr", 64'(rv), 64'h0000_0043);
    check("full_head_index", 64'(bus.row_index), 64'd0);
    check("full_head_data",  64'(bus.row_data), 64'h3F_0000_0100);

    // Push while full with a simultaneous pop.
    bus.row_ready = 1'b1;
    wr(5, 32'hAAAA_5555, 4'hF);
    bus.row_ready = 1'b0;
    rd(STAT_W, rv);
    check("full_pop_push_status", 64'(rv), 64'h0000_0043);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_valid%0d", k), 64'(bus.row_valid), 64'd1);
      check($sformatf("drain_index%0d", k), 64'(bus.row_index), 64'(exp_idx[k]));
      if (k == 3) check("drain_tail_data", 64'(bus.row_data), 64'h00_AAAA_5555);
      bus.row_ready = 1'b1; step(); bus.row_ready = 1'b0;
    end
    check("drain_empty", 64'(bus.row_valid), 64'd0);

    // Text port.
    wr(64 + 10, 32'h00AB_0000, 4'h4);
    check("txt_we_pulse", 64'(bus.txt_we), 64'd1);
    check("txt_addr",     64'(bus.txt_addr), 64'd10);
    check("txt_data",     64'(bus.txt_data), 64'hAB);
    step();
    check("txt_we_one_cycle", 64'(bus.txt_we), 64'd0);
    wr(64 + 11, 32'h1111_1111, 4'h0);
    check("txt_no_strobe", 64'(bus.txt_we), 64'd0);
    rd(64 + 10, rv);
    check("txt_read_zero", 64'(rv), 64'd0);

    // Byte strobes, unmapped reads/writes.
    wr(3, 32'hFFFF_FFFF, 4'hF);
    wr(3, 32'h0000_0000, 4'h1);
    rd(3, rv);
    check("strobe_merge", 64'(rv), 64'hFFFF_FF00);
    rd(50, rv);
    check("unmapped_read", 64'(rv), 64'd0);
    rd(STAT_W + 1, rv);
    check("unmapped_read_39", 64'(rv), 64'd0);
    wr(50, 32'hDEAD_BEEF, 4'hF);
    rd(STAT_W, rv);
    check("unmapped_write_noop", 64'(rv), 64'h0000_0021);

    // Simultaneous write and read of the same row returns the old value.
    bus.user_addr = 32'(3) << 2; bus.user_wr_data = 32'h55; bus.user_wstrb = 4'hF;
    bus.user_wren = 1'b1; bus.user_rden = 1'b1;
    step();
    bus.user_wren = 1'b0; bus.user_rden = 1'b0;
    check("rw_same_old", 64'(bus.user_rd_data), 64'hFFFF_FF00);
    rd(3, rv);
    check("rw_same_new", 64'(rv), 64'h55);
    rd(STAT_W, rv);
    check("level3_status", 64'(rv), 64'h0000_0031);

    // Reset mid-operation with 3 queued rows and a text pulse in flight.
    bus.user_addr = 32'(64) << 2; bus.user_wr_data = 32'h5A; bus.user_wstrb = 4'h1;
    bus.user_wren = 1'b1;
    step();
    bus.user_wren = 1'b0;
    check("pre_rst_txt_we", 64'(bus.txt_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check("in_rst_row_valid", 64'(bus.row_valid), 64'd0);
    check("in_rst_txt_we",    64'(bus.txt_we), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("post_rst_row_valid", 64'(bus.row_valid), 64'd0);
    check("post_rst_txt_we",    64'(bus.txt_we), 64'd0);
    rd(STAT_W, rv);
    check("post_rst_status", 64'(rv), 64'd0);
    rd(3, rv);
    check("post_rst_row3", 64'(rv), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
